// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every signal between the fetch stage, the memory stage, the shared
// unified memory and the arbiter that sequences them.
//
//   Fetch side : InstrReq, InstrAdr (to arbiter); InstrRd, InstrDone, StallF
//   Data side  : DataReq, DataWe, DataAdr, DataWd (to arbiter);
//                DataRd, DataDone, StallM
//   Memory side: MemEn, MemWe, MemAdr, MemWd (from arbiter); MemRd (to arbiter)
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding core/memory (or a testbench standing in for it)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          InstrReq;
    logic [AW-1:0] InstrAdr;
    logic [DW-1:0] InstrRd;
    logic          InstrDone;

    logic          DataReq;
    logic          DataWe;
    logic [AW-1:0] DataAdr;
    logic [DW-1:0] DataWd;
    logic [DW-1:0] DataRd;
    logic          DataDone;

    logic          MemEn;
    logic          MemWe;
    logic [AW-1:0] MemAdr;
    logic [DW-1:0] MemWd;
    logic [DW-1:0] MemRd;

    logic          StallF;
    logic          StallM;

    modport slave (
        input  InstrReq, InstrAdr, DataReq, DataWe, DataAdr, DataWd, MemRd,
        output InstrRd, InstrDone, DataRd, DataDone,
               MemEn, MemWe, MemAdr, MemWd, StallF, StallM
    );

    modport master (
        output InstrReq, InstrAdr, DataReq, DataWe, DataAdr, DataWd, MemRd,
        input  InstrRd, InstrDone, DataRd, DataDone,
               MemEn, MemWe, MemAdr, MemWd, StallF, StallM
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Sequences a single-ported unified memory shared by instruction fetch and the
// memory stage. One requester is granted at a time; address, write data and
// enables are held stable for LAT cycles, then read data is captured and a
// one-cycle Done pulse is issued to the served requester.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - mem_arbiter_if.slave (fetch, data and memory signals, stalls)
//
// Parameters:
//   LAT - memory access latency in cycles, must be >= 1
//   AW  - address width (must match the connected interface)
//   DW  - data width (must match the connected interface)
//
// Build option:
//   ARB_RR_EN - when defined, contested grants alternate between requesters
//               (the one not granted most recently wins; first contest goes
//               to DATA). When undefined, DATA always wins a contest.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } state_t;

    // Counter holds LAT-1 down to 0; keep at least one bit when LAT==1.
    localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_adr_q;
    logic [DW-1:0] mem_wd_q;
    logic [DW-1:0] instr_rd_q;
    logic [DW-1:0] data_rd_q;
    logic          instr_done_q;
    logic          data_done_q;
`ifdef ARB_RR_EN
    logic          last_instr_q;   // 1 = most recent grant went to fetch
`endif

    logic instr_elig;
    logic data_elig;
    logic grant_data_d;
    logic grant_instr_d;

    // A request still held high in its own Done cycle must not be re-served.
    assign instr_elig = bus.InstrReq & ~instr_done_q;
    assign data_elig  = bus.DataReq  & ~data_done_q;

    // The Done cycle is always followed by one further IDLE cycle before the
    // next grant, so no grant is made while any Done pulse is active. This
    // gives every requester the same turnaround regardless of who finished.
    always_comb begin
        grant_data_d  = 1'b0;
        grant_instr_d = 1'b0;
        if (state_q == IDLE && !instr_done_q && !data_done_q) begin
`ifdef ARB_RR_EN
            if (data_elig && instr_elig) begin
                grant_data_d  = last_instr_q;
                grant_instr_d = ~last_instr_q;
            end else begin
                grant_data_d  = data_elig;
                grant_instr_d = instr_elig;
            end
`else
            grant_data_d  = data_elig;
            grant_instr_d = instr_elig & ~data_elig;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_adr_q    <= '0;
            mem_wd_q     <= '0;
            instr_rd_q   <= '0;
            data_rd_q    <= '0;
            instr_done_q <= 1'b0;
            data_done_q  <= 1'b0;
`ifdef ARB_RR_EN
            last_instr_q <= 1'b1;
`endif
        end else begin
            // Done is a single-cycle pulse unless re-asserted below.
            instr_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_data_d) begin
                        state_q   <= DATA;
                        mem_en_q  <= 1'b1;
                        mem_we_q  <= bus.DataWe;
                        mem_adr_q <= bus.DataAdr;
                        mem_wd_q  <= bus.DataWd;
                        cnt_q     <= CNT_INIT;
`ifdef ARB_RR_EN
                        last_instr_q <= 1'b0;
`endif
                    end else if (grant_instr_d) begin
                        state_q   <= INSTR;
                        mem_en_q  <= 1'b1;
                        mem_we_q  <= 1'b0;
                        mem_adr_q <= bus.InstrAdr;
                        cnt_q     <= CNT_INIT;
`ifdef ARB_RR_EN
                        last_instr_q <= 1'b1;
`endif
                    end
                end
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        // Writes leave DataRd untouched.
                        if (!mem_we_q) begin
                            data_rd_q <= bus.MemRd;
                        end
                        data_done_q <= 1'b1;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                INSTR: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        instr_rd_q   <= bus.MemRd;
                        instr_done_q <= 1'b1;
                        mem_en_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MemEn     = mem_en_q;
    assign bus.MemWe     = mem_we_q;
    assign bus.MemAdr    = mem_adr_q;
    assign bus.MemWd     = mem_wd_q;
    assign bus.InstrRd   = instr_rd_q;
    assign bus.DataRd    = data_rd_q;
    assign bus.InstrDone = instr_done_q;
    assign bus.DataDone  = data_done_q;

    // Stalls are combinational so the hazard logic releases in the Done cycle.
    assign bus.StallF = bus.InstrReq & ~instr_done_q;
    assign bus.StallM = bus.DataReq  & ~data_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Three arbiter instances (LAT = 1, 2, 3) driven one scenario at a time.
// Cycle c of a scenario starts at the rising edge after which inputs are
// driven; outputs are sampled on the following falling edge. Memory read data
// is a fixed function of the presented address unless overridden.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst1_n, rst2_n, rst3_n;
    int   total = 0;
    int   bad   = 0;

    logic        rd_ovr = 1'b0;
    logic [31:0] rd_val = '0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus1();
    mem_arbiter_if #(.AW(32), .DW(32)) bus2();
    mem_arbiter_if #(.AW(32), .DW(32)) bus3();

    mem_arbiter #(.LAT(1), .AW(32), .DW(32)) dut1 (.clk(clk), .reset(rst1_n), .bus(bus1));
    mem_arbiter #(.LAT(2), .AW(32), .DW(32)) dut2 (.clk(clk), .reset(rst2_n), .bus(bus2));
    mem_arbiter #(.LAT(3), .AW(32), .DW(32)) dut3 (.clk(clk), .reset(rst3_n), .bus(bus3));

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus1.MemRd = rd_ovr ? rd_val : memf(bus1.MemAdr);
    assign bus2.MemRd = rd_ovr ? rd_val : memf(bus2.MemAdr);
    assign bus3.MemRd = rd_ovr ? rd_val : memf(bus3.MemAdr);

    task automatic clear_inputs();
        bus1.InstrReq = 0; bus1.InstrAdr = '0; bus1.DataReq = 0; bus1.DataWe = 0; bus1.DataAdr = '0; bus1.DataWd = '0;
        bus2.InstrReq = 0; bus2.InstrAdr = '0; bus2.DataReq = 0; bus2.DataWe = 0; bus2.DataAdr = '0; bus2.DataWd = '0;
        bus3.InstrReq = 0; bus3.InstrAdr = '0; bus3.DataReq = 0; bus3.DataWe = 0; bus3.DataAdr = '0; bus3.DataWd = '0;
    endtask

    task automatic test_reset();
        logic [135:0] v1, v2, v3;
        clear_inputs();
        rst1_n = 0; rst2_n = 0; rst3_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        v1 = {bus1.MemEn, bus1.MemWe, bus1.InstrDone, bus1.DataDone, bus1.MemAdr, bus1.MemWd, bus1.InstrRd, bus1.DataRd};
        v2 = {bus2.MemEn, bus2.MemWe, bus2.InstrDone, bus2.DataDone, bus2.MemAdr, bus2.MemWd, bus2.InstrRd, bus2.DataRd};
        v3 = {bus3.MemEn, bus3.MemWe, bus3.InstrDone, bus3.DataDone, bus3.MemAdr, bus3.MemWd, bus3.InstrRd, bus3.DataRd};
        total++; if (v1 !== '0) begin bad++; $display("FAIL reset_lat1 got=%h exp=0", v1); end
        total++; if (v2 !== '0) begin bad++; $display("FAIL reset_lat2 got=%h exp=0", v2); end
        total++; if (v3 !== '0) begin bad++; $display("FAIL reset_lat3 got=%h exp=0", v3); end
        rst1_n = 1; rst2_n = 1; rst3_n = 1;
        repeat (2) @(posedge clk);
        $display("reset: done");
    endtask

    // LAT=2 single fetch with a fixed memory word.
    task automatic test_fetch();
        @(posedge clk); #1;
        rd_ovr = 1; rd_val = 32'hE3A00005;
        bus2.InstrReq = 1; bus2.InstrAdr = 32'h40;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            total++; if (bus2.MemEn !== (c == 1 || c == 2)) begin bad++; $display("FAIL fetch_memen cyc=%0d got=%b exp=%b", c, bus2.MemEn, (c == 1 || c == 2)); end
            if (c == 1 || c == 2) begin
                total++; if (bus2.MemAdr !== 32'h40) begin bad++; $display("FAIL fetch_memadr cyc=%0d got=%h exp=40", c, bus2.MemAdr); end
            end
            total++; if (bus2.InstrDone !== (c == 3)) begin bad++; $display("FAIL fetch_done cyc=%0d got=%b exp=%b", c, bus2.InstrDone, (c == 3)); end
            total++; if (bus2.StallF !== (c <= 2)) begin bad++; $display("FAIL fetch_stallf cyc=%0d got=%b exp=%b", c, bus2.StallF, (c <= 2)); end
            if (c == 3) begin
                total++; if (bus2.InstrRd !== 32'hE3A00005) begin bad++; $display("FAIL fetch_rd got=%h exp=E3A00005", bus2.InstrRd); end
                bus2.InstrReq = 0;
            end
            @(posedge clk); #1;
        end
        rd_ovr = 0;
        $display("fetch: instr 0x40 read");
    endtask

    // LAT=2 fetch and data read raised together: data first, then fetch.
    task automatic test_contend();
        @(posedge clk); #1;
        bus2.InstrReq = 1; bus2.InstrAdr = 32'h44;
        bus2.DataReq = 1; bus2.DataWe = 0; bus2.DataAdr = 32'h100;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            total++; if (bus2.DataDone !== (c == 3)) begin bad++; $display("FAIL contend_ddone cyc=%0d got=%b exp=%b", c, bus2.DataDone, (c == 3)); end
            total++; if (bus2.InstrDone !== (c == 7)) begin bad++; $display("FAIL contend_idone cyc=%0d got=%b exp=%b", c, bus2.InstrDone, (c == 7)); end
            total++; if ((bus2.MemEn && bus2.MemAdr == 32'h44) !== (c == 5 || c == 6)) begin bad++; $display("FAIL contend_iadr cyc=%0d en=%b adr=%h", c, bus2.MemEn, bus2.MemAdr); end
            if (c == 3) begin
                total++; if (bus2.DataRd !== memf(32'h100)) begin bad++; $display("FAIL contend_drd got=%h exp=%h", bus2.DataRd, memf(32'h100)); end
                bus2.DataReq = 0;
            end
            if (c == 7) begin
                total++; if (bus2.InstrRd !== memf(32'h44)) begin bad++; $display("FAIL contend_ird got=%h exp=%h", bus2.InstrRd, memf(32'h44)); end
                bus2.InstrReq = 0;
            end
            @(posedge clk); #1;
        end
        $display("contend: data then instr");
    endtask

    // LAT=1: a read to set DataRd, then a write that must leave it alone.
    task automatic test_write();
        @(posedge clk); #1;
        bus1.DataReq = 1; bus1.DataWe = 0; bus1.DataAdr = 32'h20;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            total++; if (bus1.DataDone !== (c == 2)) begin bad++; $display("FAIL wr_pre_done cyc=%0d got=%b exp=%b", c, bus1.DataDone, (c == 2)); end
            if (c == 2) bus1.DataReq = 0;
            @(posedge clk); #1;
        end
        bus1.DataReq = 1; bus1.DataWe = 1; bus1.DataAdr = 32'h80; bus1.DataWd = 32'hDEADBEEF;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++; if ({bus1.MemEn, bus1.MemWe, bus1.MemAdr, bus1.MemWd} !== {2'b11, 32'h80, 32'hDEADBEEF}) begin
                    bad++; $display("FAIL wr_bus en=%b we=%b adr=%h wd=%h exp 1 1 80 DEADBEEF", bus1.MemEn, bus1.MemWe, bus1.MemAdr, bus1.MemWd); end
            end
            total++; if (bus1.DataDone !== (c == 2)) begin bad++; $display("FAIL wr_done cyc=%0d got=%b exp=%b", c, bus1.DataDone, (c == 2)); end
            if (c <= 2) begin
                total++; if (bus1.StallM !== (c <= 1)) begin bad++; $display("FAIL wr_stallm cyc=%0d got=%b exp=%b", c, bus1.StallM, (c <= 1)); end
            end
            if (c == 2) begin
                total++; if ({bus1.MemEn, bus1.MemWe} !== 2'b00) begin bad++; $display("FAIL wr_release got=%b exp=00", {bus1.MemEn, bus1.MemWe}); end
                total++; if (bus1.DataRd !== memf(32'h20)) begin bad++; $display("FAIL wr_drd_hold got=%h exp=%h", bus1.DataRd, memf(32'h20)); end
                bus1.DataReq = 0; bus1.DataWe = 0;
            end
            @(posedge clk); #1;
        end
        $display("write: 0x80 <= DEADBEEF");
    endtask

    // LAT=1, fetch request held continuously, address stepping by 4.
    task automatic test_back_to_back();
        int k = 0;
        @(posedge clk); #1;
        bus1.InstrReq = 1; bus1.InstrAdr = 32'h1000;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            total++; if (bus1.InstrDone !== (c == 2 || c == 5 || c == 8)) begin bad++; $display("FAIL b2b_done cyc=%0d got=%b", c, bus1.InstrDone); end
            total++; if (bus1.MemEn !== (c == 1 || c == 4 || c == 7)) begin bad++; $display("FAIL b2b_memen cyc=%0d got=%b", c, bus1.MemEn); end
            total++; if (bus1.MemEn && bus1.InstrDone) begin bad++; $display("FAIL b2b_overlap cyc=%0d got=1 exp=0", c); end
            if (bus1.MemEn) begin
                total++; if (bus1.MemAdr !== 32'h1000 + 32'(4 * k)) begin bad++; $display("FAIL b2b_adr cyc=%0d got=%h exp=%h", c, bus1.MemAdr, 32'h1000 + 32'(4 * k)); end
            end
            if (bus1.InstrDone) begin
                total++; if (bus1.InstrRd !== memf(32'h1000 + 32'(4 * k))) begin bad++; $display("FAIL b2b_rd cyc=%0d got=%h", c, bus1.InstrRd); end
                k++;
                bus1.InstrAdr = 32'h1000 + 32'(4 * k);
                if (k == 3) bus1.InstrReq = 0;
            end
            @(posedge clk); #1;
        end
        $display("back_to_back: %0d fetches", k);
    endtask

    // LAT=3 data read aborted by reset in cycle 2, then re-served in full.
    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus3.DataReq = 1; bus3.DataWe = 0; bus3.DataAdr = 32'h200;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            total++; if (bus3.MemEn !== (c == 1 || c == 2 || (c >= 4 && c <= 6))) begin bad++; $display("FAIL rmid_memen cyc=%0d got=%b", c, bus3.MemEn); end
            total++; if (bus3.DataDone !== (c == 7)) begin bad++; $display("FAIL rmid_done cyc=%0d got=%b exp=%b", c, bus3.DataDone, (c == 7)); end
            if (c == 2) begin
                rst3_n = 0;
                #1;
                total++; if ({bus3.MemEn, bus3.DataDone} !== 2'b00) begin bad++; $display("FAIL rmid_async got=%b exp=00", {bus3.MemEn, bus3.DataDone}); end
            end
            if (c == 3) rst3_n = 1;
            if (c == 7) begin
                total++; if (bus3.DataRd !== memf(32'h200)) begin bad++; $display("FAIL rmid_drd got=%h exp=%h", bus3.DataRd, memf(32'h200)); end
                bus3.DataReq = 0;
            end
            @(posedge clk); #1;
        end
        $display("reset_mid: aborted and re-served");
    endtask

    // LAT=1, both requests held: alternation with ARB_RR_EN, data-only without.
    task automatic test_rr();
        logic exp_d, exp_i;
        @(posedge clk); #1;
        bus1.InstrReq = 1; bus1.InstrAdr = 32'h300;
        bus1.DataReq = 1; bus1.DataWe = 0; bus1.DataAdr = 32'h400;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
`ifdef ARB_RR_EN
            exp_d = (c == 2 || c == 8);
            exp_i = (c == 5);
`else
            exp_d = (c == 2 || c == 5 || c == 8);
            exp_i = 1'b0;
`endif
            total++; if (bus1.DataDone !== exp_d) begin bad++; $display("FAIL rr_ddone cyc=%0d got=%b exp=%b", c, bus1.DataDone, exp_d); end
            total++; if (bus1.InstrDone !== exp_i) begin bad++; $display("FAIL rr_idone cyc=%0d got=%b exp=%b", c, bus1.InstrDone, exp_i); end
            if (c == 9) begin bus1.InstrReq = 0; bus1.DataReq = 0; end
            @(posedge clk); #1;
        end
        $display("rr: contested grants");
    endtask

    // LAT=2 random rounds. The model predicts completion cycles from the grant
    // order rule: the first served finishes at LAT+1, a waiting one at 2*LAT+3.
    task automatic test_random();
        localparam int L = 2;
        logic        last_instr = 1'b1;           // contend test ended with a fetch grant
        logic [31:0] drd_model  = memf(32'h100);  // last data read on this instance
        for (int r = 0; r < 30; r++) begin
            int          mode = int'($urandom_range(1, 3));
            logic        use_i = mode[0], use_d = mode[1];
            logic [31:0] ia = $urandom & 32'hFFFC, da = $urandom & 32'hFFFC, wd = $urandom;
            logic        we = 1'($urandom_range(0, 1));
            logic        data_first = 1'b1;
            int          exp_i = -1, exp_d = -1, wr_cycles = 0;
`ifdef ARB_RR_EN
            data_first = last_instr;
`endif
            if (use_i && use_d) begin
                if (data_first) begin exp_d = L + 1; exp_i = 2 * L + 3; last_instr = 1'b1; end
                else begin exp_i = L + 1; exp_d = 2 * L + 3; last_instr = 1'b0; end
            end else if (use_i) begin
                exp_i = L + 1; last_instr = 1'b1;
            end else begin
                exp_d = L + 1; last_instr = 1'b0;
            end
            if (use_d && !we) drd_model = memf(da);
            @(posedge clk); #1;
            bus2.InstrReq = use_i; bus2.InstrAdr = ia;
            bus2.DataReq = use_d; bus2.DataAdr = da; bus2.DataWe = we; bus2.DataWd = wd;
            for (int c = 0; c <= 9; c++) begin
                @(negedge clk);
                total++; if (bus2.InstrDone !== (c == exp_i)) begin bad++; $display("FAIL rnd_idone r=%0d cyc=%0d got=%b exp=%b", r, c, bus2.InstrDone, (c == exp_i)); end
                total++; if (bus2.DataDone !== (c == exp_d)) begin bad++; $display("FAIL rnd_ddone r=%0d cyc=%0d got=%b exp=%b", r, c, bus2.DataDone, (c == exp_d)); end
                if (bus2.MemEn && bus2.MemWe) begin
                    wr_cycles++;
                    total++; if ({bus2.MemAdr, bus2.MemWd} !== {da, wd}) begin bad++; $display("FAIL rnd_wbus r=%0d got=%h/%h exp=%h/%h", r, bus2.MemAdr, bus2.MemWd, da, wd); end
                end
                if (c == exp_i) begin
                    total++; if (bus2.InstrRd !== memf(ia)) begin bad++; $display("FAIL rnd_ird r=%0d got=%h exp=%h", r, bus2.InstrRd, memf(ia)); end
                    bus2.InstrReq = 0;
                end
                if (c == exp_d) begin
                    total++; if (bus2.DataRd !== drd_model) begin bad++; $display("FAIL rnd_drd r=%0d got=%h exp=%h", r, bus2.DataRd, drd_model); end
                    bus2.DataReq = 0;
                end
                @(posedge clk); #1;
            end
            total++; if (wr_cycles != ((use_d && we) ? L : 0)) begin bad++; $display("FAIL rnd_wrcnt r=%0d got=%0d exp=%0d", r, wr_cycles, (use_d && we) ? L : 0); end
            $display("random r=%0d i=%b d=%b we=%b ia=%h da=%h", r, use_i, use_d, we, ia, da);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contend();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_rr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
